// File: rtl/icache_pkg.sv
// Shared constants and types for the direct-mapped instruction cache.
// Holds line geometry, the NOP returned when no instruction is delivered, and FSM states.
package icache_pkg;

    localparam int LINE_BYTES = 16;
    localparam int OFFSET_W   = 2;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE,
        MISS,
        REFILL
    } state_t;

endpackage

// File: rtl/icache_line_array.sv
// Data + tag storage for the cache: one asynchronous read port, one synchronous write port.
// Ports: clk; we/widx/wtag/wdata write a whole line; ridx selects rtag/rdata combinationally.
module icache_line_array #(
    parameter int LINES  = 8,
    parameter int IDX_W  = $clog2(LINES),
    parameter int TAG_W  = 25,
    parameter int DATA_W = 128
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  widx,
    input  logic [TAG_W-1:0]  wtag,
    input  logic [DATA_W-1:0] wdata,
    input  logic [IDX_W-1:0]  ridx,
    output logic [TAG_W-1:0]  rtag,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] data_q [LINES];
    logic [TAG_W-1:0]  tag_q  [LINES];

    always_ff @(posedge clk) begin
        if (we) begin
            data_q[widx] <= wdata;
            tag_q[widx]  <= wtag;
        end
    end

    assign rtag  = tag_q[ridx];
    assign rdata = data_q[ridx];

endmodule

// File: rtl/icache.sv
// Direct-mapped instruction cache with zero-latency hits and single-beat ROM refill.
// Ports: IF request/address/jump in, hit/ready/inst out; ROM req/addr out, ready/data in.
module icache
    import icache_pkg::*;
#(
    parameter int LINES = 8,
    parameter int WORDS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req_Icache_i,
    input  logic [31:0]           if_addr_i,
    input  logic                  if_jump_Icache_i,
    output logic                  Icache_hit_o,
    output logic                  Icache_ready_o,
    output logic [31:0]           Icache_inst_o,
    output logic                  rom_req_o,
    output logic [31:0]           rom_addr_o,
    input  logic                  rom_ready_i,
    input  logic [32*WORDS-1:0]   rom_data_i
);

    localparam int IDX_W  = $clog2(LINES);
    localparam int IDX_LO = 2 + OFFSET_W;
    localparam int TAG_LO = IDX_LO + IDX_W;
    localparam int TAG_W  = 32 - TAG_LO;

    state_t               state_q;
    state_t               state_d;
    logic [LINES-1:0]     valid_q;
    logic                 drop_q;
    logic                 rdy_prev_q;
    logic [31:2]          addr_q;

    logic [IDX_W-1:0]     req_idx;
    logic [TAG_W-1:0]     req_tag;
    logic [IDX_W-1:0]     miss_idx;
    logic [IDX_W-1:0]     ridx;
    logic [OFFSET_W-1:0]  roff;
    logic [TAG_W-1:0]     rtag;
    logic [32*WORDS-1:0]  rdata;
    logic [31:0]          word;
    logic                 rom_edge;
    logic                 fill;
    logic                 unused_addr_bits;

    assign unused_addr_bits = ^if_addr_i[1:0];

    assign req_idx  = if_addr_i[TAG_LO-1:IDX_LO];
    assign req_tag  = if_addr_i[31:TAG_LO];
    assign miss_idx = addr_q[TAG_LO-1:IDX_LO];

    // Lookups use the live address while idle; the refill cycle reads back the
    // line just written, at the latched miss address.
    assign ridx = (state_q == IDLE) ? req_idx : miss_idx;
    assign roff = (state_q == IDLE) ? if_addr_i[3:2] : addr_q[3:2];
    assign word = rdata[32*roff +: 32];

    // Only a rising edge of ROM ready completes a refill, so a held-high
    // ready cannot write the line twice.
    assign rom_edge = rom_ready_i & ~rdy_prev_q;
    assign fill     = (state_q == MISS) & rom_edge;

    icache_line_array #(
        .LINES  (LINES),
        .IDX_W  (IDX_W),
        .TAG_W  (TAG_W),
        .DATA_W (32*WORDS)
    ) u_array (
        .clk   (clk),
        .we    (fill),
        .widx  (miss_idx),
        .wtag  (addr_q[31:TAG_LO]),
        .wdata (rom_data_i),
        .ridx  (ridx),
        .rtag  (rtag),
        .rdata (rdata)
    );

    always_comb begin
        state_d        = state_q;
        Icache_hit_o   = 1'b0;
        Icache_ready_o = 1'b0;
        rom_req_o      = 1'b0;
        rom_addr_o     = 32'h0;
        unique case (state_q)
            IDLE: begin
                Icache_hit_o   = if_req_Icache_i & valid_q[ridx] &
                                 (rtag == req_tag);
                Icache_ready_o = Icache_hit_o;
                if (if_req_Icache_i && !Icache_hit_o) begin
                    state_d = MISS;
                end
            end
            MISS: begin
                rom_req_o  = 1'b1;
                rom_addr_o = {addr_q[31:4], 4'b0};
                if (rom_edge) begin
                    state_d = REFILL;
                end
            end
            REFILL: begin
                Icache_ready_o = ~drop_q & ~if_jump_Icache_i;
                state_d        = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        Icache_inst_o = Icache_ready_o ? word : NOP;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            valid_q    <= '0;
            drop_q     <= 1'b0;
            rdy_prev_q <= 1'b0;
            addr_q     <= '0;
        end else begin
            state_q    <= state_d;
            rdy_prev_q <= rom_ready_i;
            if (state_q == IDLE && state_d == MISS) begin
                addr_q <= if_addr_i[31:2];
            end
            if (fill) begin
                valid_q[miss_idx] <= 1'b1;
            end
            if (state_d == IDLE) begin
                drop_q <= 1'b0;
            end else if (state_q == MISS && if_jump_Icache_i) begin
                drop_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: directed scenarios plus randomized traffic
// compared every cycle against a line-address-level cache model.
module tb_icache;

    localparam int LINES = 8;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         if_req = 1'b0;
    logic [31:0]  addr = 32'h0;
    logic         jump = 1'b0;
    logic         rom_ready = 1'b0;
    logic [127:0] rom_data;
    logic         hit_o;
    logic         ready_o;
    logic [31:0]  inst_o;
    logic         rom_req_o;
    logic [31:0]  rom_addr_o;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(logic [31:0] la, int w);
        logic [31:0] k;
        if (la == 32'h100) begin
            case (w)
                0: return 32'h1111_0000;
                1: return 32'hDEAD_BEEF;
                2: return 32'h2222_0000;
                default: return 32'h600D_F00D;
            endcase
        end
        k = 32'h9E37_0000 * 32'(w + 1);
        return la ^ k;
    endfunction

    function automatic logic [127:0] rom_line(logic [31:0] la);
        return {rom_word(la, 3), rom_word(la, 2),
                rom_word(la, 1), rom_word(la, 0)};
    endfunction

    assign rom_data = rom_line(rom_addr_o);

    icache #(.LINES(LINES), .WORDS(4)) dut (
        .clk              (clk),
        .rst              (rst),
        .if_req_Icache_i  (if_req),
        .if_addr_i        (addr),
        .if_jump_Icache_i (jump),
        .Icache_hit_o     (hit_o),
        .Icache_ready_o   (ready_o),
        .Icache_inst_o    (inst_o),
        .rom_req_o        (rom_req_o),
        .rom_addr_o       (rom_addr_o),
        .rom_ready_i      (rom_ready),
        .rom_data_i       (rom_data)
    );

    task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
        end
    endtask

    // Model: the cache is a set of resident line addresses; a miss is a
    // pending transaction that resolves on a ROM ready rising edge and is
    // delivered on the following cycle.
    bit          m_valid [LINES];
    logic [31:0] m_line  [LINES];
    bit          busy = 0, deliver = 0, drop = 0, ddrop = 0, prev = 0;
    logic [31:0] baddr = 0, daddr = 0;

    function automatic int idx_of(logic [31:0] a);
        return int'((a >> 4) % LINES);
    endfunction

    function automatic logic [31:0] line_of(logic [31:0] a);
        return a & ~32'hF;
    endfunction

    function automatic bit model_hit();
        int i;
        i = idx_of(addr);
        return if_req && !busy && !deliver && m_valid[i] &&
               (m_line[i] == line_of(addr));
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LINES; i++) m_valid[i] = 0;
            busy = 0; deliver = 0; drop = 0; prev = 0;
        end else begin
            bit h;
            bit redge;
            h     = model_hit();
            redge = rom_ready && !prev;
            if (deliver) begin
                deliver = 0;
            end else if (busy) begin
                if (jump) drop = 1;
                if (redge) begin
                    m_valid[idx_of(baddr)] = 1;
                    m_line[idx_of(baddr)]  = line_of(baddr);
                    busy    = 0;
                    deliver = 1;
                    ddrop   = drop;
                    daddr   = baddr;
                end
            end else if (if_req && !h) begin
                busy  = 1;
                baddr = addr;
                drop  = 0;
            end
            prev = rom_ready;
        end
    end

    always @(negedge clk) begin
        logic        e_hit, e_rdy, e_req;
        logic [31:0] e_inst, e_addr;
        e_hit = 0; e_rdy = 0; e_req = 0; e_inst = NOP; e_addr = 0;
        if (rst) begin
            e_hit = 0;
        end else if (deliver) begin
            e_rdy = !ddrop && !jump;
            if (e_rdy) e_inst = rom_word(line_of(daddr), int'(daddr[3:2]));
        end else if (busy) begin
            e_req  = 1;
            e_addr = line_of(baddr);
        end else begin
            e_hit = model_hit();
            e_rdy = e_hit;
            if (e_hit) e_inst = rom_word(line_of(addr), int'(addr[3:2]));
        end
        chk("hit", 32'(hit_o), 32'(e_hit));
        chk("ready", 32'(ready_o), 32'(e_rdy));
        chk("inst", inst_o, e_inst);
        chk("rom_req", 32'(rom_req_o), 32'(e_req));
        chk("rom_addr", rom_addr_o, e_addr);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req();
        int n = 0;
        while (!rom_req_o && n < 20) begin
            step();
            n++;
        end
        chk("rom_req_timeout", 32'(rom_req_o), 32'd1);
    endtask

    initial begin
        int rcnt;
        rst = 1;
        repeat (3) step();
        chk("rst_hit", 32'(hit_o), 0);
        chk("rst_ready", 32'(ready_o), 0);
        chk("rst_rom_req", 32'(rom_req_o), 0);
        chk("rst_rom_addr", rom_addr_o, 0);
        chk("rst_inst", inst_o, NOP);
        rst = 0;
        step();

        // cold miss
        if_req = 1; addr = 32'h104;
        step();
        wait_req();
        chk("cold_rom_addr", rom_addr_o, 32'h100);
        rom_ready = 1;
        step();
        chk("cold_ready", 32'(ready_o), 1);
        chk("cold_inst", inst_o, 32'hDEAD_BEEF);
        rom_ready = 0;
        step();
        chk("rehit", 32'(hit_o), 1);

        // warm hit
        addr = 32'h10C; #1;
        chk("warm_hit", 32'(hit_o), 1);
        chk("warm_ready", 32'(ready_o), 1);
        chk("warm_inst", inst_o, 32'h600D_F00D);

        // conflict
        addr = 32'h180; #1;
        chk("conf_miss", 32'(hit_o), 0);
        step();
        wait_req();
        chk("conf_rom_addr", rom_addr_o, 32'h180);
        rom_ready = 1;
        step();
        chk("conf_inst", inst_o, 32'h9E37_0180);
        rom_ready = 0;
        step();
        addr = 32'h100; #1;
        chk("evicted_miss", 32'(hit_o), 0);
        step();
        wait_req();
        chk("evict_rom_addr", rom_addr_o, 32'h100);
        rom_ready = 1;
        step();
        chk("evict_inst", inst_o, 32'h1111_0000);
        rom_ready = 0;
        step();

        // jump during miss
        addr = 32'h200; #1;
        step();
        wait_req();
        step(); step();
        jump = 1;
        step();
        jump = 0; rom_ready = 1;
        step();
        chk("drop_ready", 32'(ready_o), 0);
        chk("drop_inst", inst_o, NOP);
        rom_ready = 0;
        step();
        chk("after_drop_hit", 32'(hit_o), 1);
        chk("after_drop_inst", inst_o, 32'h9E37_0200);

        // held rom ready
        addr = 32'h300; #1;
        step();
        wait_req();
        rom_ready = 1;
        step();
        chk("held_ready", 32'(ready_o), 1);
        chk("held_inst", inst_o, 32'h9E37_0300);
        if_req = 0;
        rcnt = 1;
        for (int i = 0; i < 4; i++) begin
            step();
            if (i == 1) rom_ready = 0;
            #1;
            rcnt += int'(ready_o);
        end
        chk("held_pulses", 32'(rcnt), 1);
        if_req = 1; addr = 32'h304; #1;
        chk("held_hit", 32'(hit_o), 1);
        chk("held_hit_inst", inst_o, 32'h3C6E_0300);
        if_req = 0;
        step();

        // reset in the middle of a miss
        if_req = 1; addr = 32'h400; #1;
        step();
        wait_req();
        rst = 1; #1;
        chk("rstmiss_rom_req", 32'(rom_req_o), 0);
        step();
        rst = 0; if_req = 0;
        step();
        rom_ready = 1;
        step();
        chk("late_rom_ready", 32'(ready_o), 0);
        rom_ready = 0;
        step();
        chk("late_rom_ready2", 32'(ready_o), 0);
        for (int i = 0; i < 4; i++) begin
            if_req = 1; addr = 32'h100 + 32'(i) * 32'h100; #1;
            chk("post_rst_miss", 32'(hit_o), 0);
            if_req = 0;
            step();
        end

        // randomized traffic
        for (int c = 0; c < 4000; c++) begin
            step();
            rst       = ($urandom_range(0, 299) == 0);
            if_req    = ($urandom_range(0, 9) < 7);
            addr      = {21'h0, 7'($urandom_range(0, 63)), 4'($urandom)};
            jump      = ($urandom_range(0, 19) == 0);
            rom_ready = ($urandom_range(0, 2) == 0);
        end
        step();
        rst = 0; if_req = 0; jump = 0; rom_ready = 0;
        repeat (4) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/icache.md
ICACHE -- requirements
Module: icache

Interface
REQ-001 SHALL have parameter LINES, default 8, number of direct-mapped lines (power of two).
REQ-002 SHALL have parameter WORDS, default 4, 32-bit words per line (fixed at 4 for a 128-bit ROM beat).
REQ-003 clk  input  1  sole clock; all state changes on rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-high.
REQ-005 if_req_Icache_i  input  1  IF fetch request, level, held while the IF stage is stalled.
REQ-006 if_addr_i  input  32  fetch byte address; bits [1:0] ignored.
REQ-007 if_jump_Icache_i  input  1  redirect: the current outstanding fetch is abandoned.
REQ-008 Icache_hit_o  output  1  combinational hit for the current request.
REQ-009 Icache_ready_o  output  1  Icache_inst_o valid this cycle.
REQ-010 Icache_inst_o  output  32  fetched instruction.
REQ-011 rom_req_o  output  1  line refill request, level.
REQ-012 rom_addr_o  output  32  16-byte-aligned line address.
REQ-013 rom_ready_i  input  1  ROM data valid; may stay high for several cycles.
REQ-014 rom_data_i  input  128  refill line; word 0 in bits [31:0].

Function
REQ-015 Address split: offset [3:2], index [3+log2(LINES):4], tag = remaining upper bits.
REQ-016 FSM states IDLE, MISS, REFILL; reset state IDLE.
REQ-017 IDLE: Icache_hit_o = if_req_Icache_i & valid[index] & tag match; on hit, Icache_ready_o=1 and Icache_inst_o = stored word, same cycle (zero latency).
REQ-018 IDLE with request and miss: latch address; next cycle go to MISS; Icache_ready_o=0.
REQ-019 MISS: rom_req_o=1, rom_addr_o = {latched[31:4],4'b0}, held constant until the refill completes.
REQ-020 MISS: refill completes on the first cycle in which rom_ready_i=1 after being 0 in the previous cycle (rising edge); then write line, set valid, write tag, and go to REFILL.
REQ-021 REFILL: lasts one cycle; Icache_ready_o=1 and Icache_inst_o = latched-offset word of the new line; rom_req_o=0; then go to IDLE.
REQ-022 In MISS and REFILL, Icache_hit_o=0 and new requests are ignored.
REQ-023 if_jump_Icache_i in MISS: the ROM transaction is not aborted; a drop flag is set; the line is still written; the REFILL cycle then drives Icache_ready_o=0.
REQ-024 if_jump_Icache_i in REFILL: suppress Icache_ready_o in that cycle; the line write is unaffected.
REQ-025 if_jump_Icache_i in IDLE: evaluate the request normally (jump target lookup); hit and ready behave per REQ-017.
REQ-026 The drop flag clears on entry to IDLE.
REQ-027 When not ready, Icache_inst_o = 32'h00000013 (NOP).
REQ-028 rom_ready_i while in IDLE or REFILL SHALL be ignored.

Reset
REQ-029 Assertion of rst clears all valid bits, the FSM (IDLE), the drop flag, and the rom_ready_i history register, asynchronously.
REQ-030 Outputs during reset: Icache_hit_o=0, Icache_ready_o=0, rom_req_o=0, rom_addr_o=0, Icache_inst_o=NOP.
REQ-031 Reset during MISS abandons the refill; no line is written; later ROM responses are ignored per REQ-028.
REQ-032 Data and tag arrays SHALL NOT be reset.

Structure
REQ-033 Shared package icache_pkg SHALL hold LINE_BYTES, OFFSET_W, the NOP constant, and the FSM state enum.
REQ-034 Data and tag storage SHALL be one sub-module icache_line_array: 1 async read port, 1 sync write port, 128-bit data plus tag.
REQ-035 The valid bits, FSM, and drop flag SHALL reside in icache.

Verification
REQ-036 Cold miss: req at 0x0000_0104 -> rom_req_o=1 with rom_addr_o=0x0000_0100; ROM returns line {w3..w0} with w1=0xDEADBEEF -> next cycle Icache_ready_o=1, Icache_inst_o=0xDEADBEEF.
REQ-037 Warm hit: after REQ-036, req 0x0000_010C -> same-cycle Icache_hit_o=1, Icache_ready_o=1, inst = w3.
REQ-038 Conflict: req 0x0000_0180 (same index 0, different tag) -> miss, refill from 0x0000_0180; then 0x0000_0100 misses again.
REQ-039 Jump during MISS: jump pulse 2 cycles after rom_req_o rises -> ROM still completes, REFILL cycle has Icache_ready_o=0; a subsequent req to the same line hits.
REQ-040 Held ROM ready: rom_ready_i high for 3 cycles -> exactly one line write and one ready pulse.
REQ-041 Reset mid-MISS: rst for 1 cycle in MISS -> rom_req_o=0, all lookups miss, a late rom_ready_i edge produces no ready.
